// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op encodings, FSM states and default width for the mul/div unit
package muldiv_unit_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opT;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } stateT;

    // The low op bit marks the unsigned flavour, the high bit marks divide.
    function automatic logic isSignedOp(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic isDivOp(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               isDiv,
    output logic [2*WIDTH-1:0] accNext
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;

    // Divide: acc = {remainder, remaining dividend bits}; multiply: acc = {partial product, multiplier}.
    always_comb begin
        accNext = '0;
        sum     = '0;
        partial = '0;
        diff    = '0;
        if (isDiv) begin
            partial = acc[2*WIDTH-1:WIDTH-1];
            diff    = partial[WIDTH-1:0] - operand;
            if (partial >= {1'b0, operand}) begin
                accNext = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
            accNext = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multicycle MULT/MULTU/DIV/DIVU unit owning the HI/LO result pair
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    stateT              state;
    logic               isDivReg;
    logic               signP;
    logic               signR;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               signedIn;

    assign signedIn = isSignedOp(op);
    assign magA     = (signedIn && a[WIDTH-1]) ? -a : a;
    assign magB     = (signedIn && b[WIDTH-1]) ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .acc     (acc),
        .operand (operand),
        .isDiv   (isDivReg),
        .accNext (accNext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            counter  <= '0;
            isDivReg <= 1'b0;
            signP    <= 1'b0;
            signR    <= 1'b0;
            acc      <= '0;
            operand  <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        isDivReg <= isDivOp(op);
                        signP    <= signedIn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        signR    <= signedIn & a[WIDTH-1];
                        busy     <= 1'b1;
                        // Divide by zero skips the datapath entirely so hi/lo keep their old values.
                        if (isDivOp(op) && (b == '0)) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, magA};
                            operand <= magB;
                            counter <= CNT_W'(WIDTH);
                            state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc     <= accNext;
                    counter <= counter - 1'b1;
                    if (counter == CNT_W'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (isDivReg) begin
                        hi <= signR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        lo <= signP ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= signP ? -acc : acc;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   opIn;
    logic [W-1:0] aIn;
    logic [W-1:0] bIn;
    logic         busy;
    logic         done;
    logic         divZero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] expHi = '0;
    logic [W-1:0] expLo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (opIn),
        .a        (aIn),
        .b        (bIn),
        .busy     (busy),
        .done     (done),
        .div_zero (divZero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % already truncate toward zero.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint          sa, sb, sp;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        h  = expHi;
        l  = expLo;
        case (op)
            2'b00: begin sp = sa * sb; {h, l} = sp; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
            2'b10: if (b == 0) dz = 1'b1; else begin l = W'(sa / sb); h = W'(sa % sb); end
            default: if (b == 0) dz = 1'b1; else begin l = a / b; h = a % b; end
        endcase
    endtask

    // Called just after a rising edge; issues the op in cycle 0 and watches done/busy timing.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int pulse1, input int pulse2);
        logic [W-1:0] eh, el, gotHi, gotLo;
        logic         edz, gotDz;
        int           lat, doneCnt, doneAt, busyBad;
        model(op, a, b, eh, el, edz);
        lat     = edz ? 1 : W + 2;
        doneCnt = 0;
        doneAt  = -1;
        busyBad = 0;
        gotHi   = '0;
        gotLo   = '0;
        gotDz   = 1'b0;
        start = 1'b1; opIn = op; aIn = a; bIn = b;
        for (int c = 1; c <= lat + 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                doneCnt++;
                if (doneAt < 0) doneAt = c;
                gotHi = hi; gotLo = lo; gotDz = divZero;
            end
            if ((c <= lat) != busy) busyBad++;
            if (c == pulse1 || c == pulse2) begin
                start = 1'b1; opIn = 2'($urandom); aIn = $urandom; bIn = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        checkEq({tag, " doneCount"}, 64'(doneCnt), 64'd1);
        checkEq({tag, " doneCycle"}, 64'(doneAt), 64'(lat));
        checkEq({tag, " busyProfile"}, 64'(busyBad), 64'd0);
        checkEq({tag, " divZero"}, {63'b0, gotDz}, {63'b0, edz});
        checkEq({tag, " hi"}, {32'b0, gotHi}, {32'b0, eh});
        checkEq({tag, " lo"}, {32'b0, gotLo}, {32'b0, el});
        expHi = eh;
        expLo = el;
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int doneCnt;
        reset = 1'b1; start = 1'b0; opIn = '0; aIn = '0; bIn = '0;
        repeat (3) @(posedge clk);
        #1;
        checkEq("reset busy", {63'b0, busy}, 64'd0);
        checkEq("reset done", {63'b0, done}, 64'd0);
        checkEq("reset divZero", {63'b0, divZero}, 64'd0);
        checkEq("reset hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        runOp("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        runOp("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, -1, -1);
        runOp("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1);
        runOp("divu by0", 2'b11, 32'd7, 32'd0, -1, -1);
        runOp("div by0", 2'b10, 32'h8000_0000, 32'd0, -1, -1);
        runOp("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        runOp("mult restart", 2'b00, 32'h1234_5678, 32'hFEDC_BA98, 5, W + 2);

        for (int i = 0; i < 30; i++) begin
            runOp($sformatf("rand%0d", i), 2'($urandom), pickOperand(), pickOperand(), -1, -1);
        end

        // Reset in cycle 10 of a DIVU: no done may follow and hi/lo clear.
        start = 1'b1; opIn = 2'b11; aIn = 32'hDEAD_BEEF; bIn = 32'd3;
        doneCnt = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (done) doneCnt++;
            if (c == 11) begin
                checkEq("midreset busy", {63'b0, busy}, 64'd0);
                checkEq("midreset hilo", {hi, lo}, 64'd0);
            end
            start = 1'b0;
            reset = (c == 10);
        end
        checkEq("midreset noDone", 64'(doneCnt), 64'd0);
        expHi = '0;
        expLo = '0;
        runOp("multu 6*7", 2'b01, 32'd6, 32'd7, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
